// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// mult_pkg : shared state encoding and defaults for the multiplier sequencer
// Rev 1.0 : initial release
// ============================================================================
package mult_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY,
    S_DONE = ST_DONE
  } state_t;

  // Step counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arb_seq_if.sv
`default_nettype none
// ============================================================================
// mult_arb_seq_if : two operand request ports plus tagged product response
// Rev 1.0 : initial release
// ============================================================================
interface mult_arb_seq_if
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);

  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic               busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_product, busy
  );

endinterface
`default_nettype wire

// File: rtl/mult_arb_seq_shift_add_core.sv
`default_nettype none
// ============================================================================
// shift_add_core : unsigned shift-add multiplier, one partial product per step
// Rev 1.0 : initial release
// ============================================================================
module shift_add_core
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk1,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] acc_next
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [CNT_W-1:0]   r_cnt;

  // Accumulator value after the current step, so the final product includes it.
  assign acc_next = r_acc + (r_mplr[0] ? r_mcand : '0);
  assign last     = (r_cnt == CNT_LAST);

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (load) begin
      r_mcand <= {{WIDTH{1'b0}}, a};
      r_mplr  <= b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (step) begin
      r_acc   <= acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mult_arb_seq.sv
`default_nettype none
// ============================================================================
// mult_arb_seq : round-robin arbiter and sequencer for a shared shift-add core
// Rev 1.0 : initial release
// ============================================================================
module mult_arb_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic            clk1,
  input  logic            reset,
  mult_arb_seq_if.slave   bus
);

  state_t             r_state;
  logic               r_last_grant;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [2*WIDTH-1:0] r_rsp_product;
  logic               r_busy;

  logic               w_idle;
  logic               w_grant;
  logic               w_accept;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_last;
  logic [2*WIDTH-1:0] w_acc_next;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    w_idle   = (r_state == S_IDLE);
    w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    w_accept = w_idle && (bus.req0_valid || bus.req1_valid);
    w_a      = w_grant ? bus.req1_a : bus.req0_a;
    w_b      = w_grant ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready  = w_idle & ~w_grant & bus.req0_valid;
  assign bus.req1_ready  = w_idle &  w_grant & bus.req1_valid;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_product = r_rsp_product;
  assign bus.busy        = r_busy;

  shift_add_core #(
    .WIDTH    (WIDTH)
  ) u_core (
    .clk1     (clk1),
    .reset    (reset),
    .load     (w_accept),
    .step     (r_state == S_BUSY),
    .a        (w_a),
    .b        (w_b),
    .last     (w_last),
    .acc_next (w_acc_next)
  );

  always_ff @(posedge clk1) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_product <= '0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_BUSY;
            r_busy       <= 1'b1;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
          end
        end
        S_BUSY: begin
          if (w_last) begin
            r_state       <= S_DONE;
            r_rsp_valid   <= 1'b1;
            r_rsp_product <= w_acc_next;
          end
        end
        S_DONE: begin
          // Returning to IDLE blocks acceptance on the same edge as the take.
          if (bus.rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_arb_seq.sv
`default_nettype none
// ============================================================================
// tb_mult_arb_seq : scoreboard bench for the arbitrated shift-add multiplier
// Rev 1.0 : initial release
// ============================================================================
module tb_mult_arb_seq;
  import mult_pkg::*;

  localparam int W = WIDTH_DEFAULT;

  typedef struct {
    bit              id;
    logic [2*W-1:0]  prod;
    int              acc_edge;
  } exp_t;

  logic clk1  = 1'b0;
  logic reset = 1'b1;
  always #5 clk1 = ~clk1;

  mult_arb_seq_if #(.WIDTH(W)) bus ();

  mult_arb_seq #(.WIDTH(W)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sbq[$];
  bit   resp_ids[$];
  bit   m_last = 1'b1;
  bit   m_inflight = 1'b0;
  bit   prev_valid = 1'b0;
  logic [2*W-1:0] held_prod;
  bit   held_id;
  int   take_edge = -1;
  int   accept_edge = -1;
  int   rmode = 1;
  int   vage = 0;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reference arbitration rules, scoreboard push on accept, pop on response.
  always @(negedge clk1) begin
    bit   g;
    bit   any_rdy;
    exp_t e;
    if (reset) begin
      sbq.delete();
      m_last     = 1'b1;
      m_inflight = 1'b0;
      prev_valid = 1'b0;
    end else begin
      any_rdy = bus.req0_ready | bus.req1_ready;
      check("busy", bus.busy, m_inflight);
      check("ready_any", any_rdy, !m_inflight && (bus.req0_valid || bus.req1_valid));
      if (any_rdy) begin
        g = bus.req1_ready;
        check("one_ready", bus.req0_ready & bus.req1_ready, 0);
        if (bus.req0_valid && bus.req1_valid) check("rr_grant", g, !m_last);
        else                                  check("sole_grant", g, bus.req1_valid);
        e.id       = g;
        e.prod     = g ? (2*W)'(bus.req1_a) * (2*W)'(bus.req1_b)
                       : (2*W)'(bus.req0_a) * (2*W)'(bus.req0_b);
        e.acc_edge = cyc + 1;
        sbq.push_back(e);
        m_last      = g;
        m_inflight  = 1'b1;
        accept_edge = cyc + 1;
      end
      if (bus.rsp_valid) begin
        if (!prev_valid) begin
          check("pending_ops", sbq.size(), 1);
          if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("rsp_product", bus.rsp_product, e.prod);
            check("rsp_id", bus.rsp_id, e.id);
            check("latency", cyc - e.acc_edge, W);
            resp_ids.push_back(bus.rsp_id);
          end
          held_prod = bus.rsp_product;
          held_id   = bus.rsp_id;
        end else begin
          check("hold_product", bus.rsp_product, held_prod);
          check("hold_id", bus.rsp_id, held_id);
        end
        if (bus.rsp_ready) begin
          prev_valid = 1'b0;
          m_inflight = 1'b0;
          take_edge  = cyc + 1;
        end else begin
          prev_valid = 1'b1;
        end
      end else begin
        if (prev_valid) check("valid_held", bus.rsp_valid, 1);
        prev_valid = 1'b0;
      end
    end
  end

  // Consumer: 0 = random ready, 1 = always ready, 2 = stall 5 cycles per response.
  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk1);
      #1;
      case (rmode)
        0: bus.rsp_ready = 1'($urandom % 2);
        1: bus.rsp_ready = 1'b1;
        default: begin
          if (bus.rsp_valid) begin
            vage++;
            bus.rsp_ready = (vage > 5);
          end else begin
            vage = 0;
            bus.rsp_ready = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit change, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    @(posedge clk1);
    #1;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; end
    while (!got && waits < 300) begin
      @(negedge clk1);
      got = id ? bus.req1_ready : bus.req0_ready;
      if (!got) waits++;
    end
    check("accepted", got, 1);
    @(posedge clk1);
    #1;
    if (id) begin
      bus.req1_valid = 1'b0;
      bus.req1_a = change ? W'(99) : W'($urandom);
    end else begin
      bus.req0_valid = 1'b0;
      bus.req0_a = change ? W'(99) : W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || bus.busy || bus.rsp_valid) && n < 400) begin
      @(negedge clk1);
      n++;
    end
    check("drain_done", n < 400, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk1);
    #1 reset = 1'b1;
    @(posedge clk1);
    #1 reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom % 4)
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  int w;
  int take1;

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    repeat (3) @(posedge clk1);
    #1 reset = 1'b0;
    @(negedge clk1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_id", bus.rsp_id, 0);
    check("reset_rsp_product", bus.rsp_product, 0);
    check("reset_busy", bus.busy, 0);

    // Single request, always-ready consumer.
    rmode = 1;
    send(1'b0, 8'd3, 8'd5, 1'b0, w);
    check("first_idle_ready", w, 0);
    drain();

    // Both valid straight out of reset: requester 0 wins the first tie.
    pulse_reset();
    resp_ids.delete();
    fork
      send(1'b0, 8'd2, 8'd1, 1'b0, w);
      send(1'b1, 8'd255, 8'd255, 1'b0, w);
    join
    drain();
    check("tie_count", resp_ids.size(), 2);
    if (resp_ids.size() == 2) begin
      check("tie_first", resp_ids[0], 0);
      check("tie_second", resp_ids[1], 1);
    end
    resp_ids.delete();
    fork
      begin send(1'b0, 8'd6, 8'd7, 1'b0, w); send(1'b0, 8'd8, 8'd9, 1'b0, w); end
      begin send(1'b1, 8'd10, 8'd11, 1'b0, w); send(1'b1, 8'd12, 8'd13, 1'b0, w); end
    join
    drain();
    check("alt_count", resp_ids.size(), 4);
    if (resp_ids.size() == 4) begin
      for (int i = 0; i < 4; i++) check("alt_order", resp_ids[i], i % 2);
    end

    // Back-pressure; a second request waits and is accepted one edge after the take.
    rmode = 2;
    send(1'b0, 8'd12, 8'd10, 1'b0, w);
    send(1'b1, 8'd1, 8'd1, 1'b0, w);
    take1 = take_edge;
    check("accept_after_take", accept_edge, take1 + 1);
    drain();

    // Zero operand still takes full latency.
    rmode = 1;
    send(1'b0, 8'd0, 8'd200, 1'b0, w);
    drain();

    // Reset on the fourth busy edge discards the operation.
    send(1'b0, 8'd7, 8'd9, 1'b0, w);
    repeat (3) @(posedge clk1);
    #1 reset = 1'b1;
    @(posedge clk1);
    #1 reset = 1'b0;
    @(negedge clk1);
    check("midreset_busy", bus.busy, 0);
    check("midreset_rsp_valid", bus.rsp_valid, 0);
    repeat (12) @(negedge clk1);
    send(1'b0, 8'd7, 8'd9, 1'b0, w);
    drain();

    // Operand changes after acceptance have no effect.
    send(1'b0, 8'd4, 8'd4, 1'b1, w);
    drain();

    // Randomised traffic from both requesters with random back-pressure.
    rmode = 0;
    fork
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom % 4) @(posedge clk1);
        send(1'b0, rand_op(), rand_op(), 1'b0, w);
      end
      for (int j = 0; j < 12; j++) begin
        repeat ($urandom % 4) @(posedge clk1);
        send(1'b1, rand_op(), rand_op(), 1'b0, w);
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
